// File: rtl/famiclone_detect_pkg.sv
// Shared encodings for the famiclone probe and the CIRAM/NTRAM steering that consumes its result.
package famiclone_detect_pkg;

  typedef enum logic [1:0] {
    ST_INIT    = 2'd0,
    ST_OBSERVE = 2'd1,
    ST_DONE    = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    FM_AUTO  = 2'b00,
    FM_ORIG  = 2'b01,
    FM_CLONE = 2'b10,
    FM_RERUN = 2'b11
  } force_e;

  // Bits needed to hold values 0..n, never less than one bit.
  function automatic int unsigned ctr_w(input int unsigned n);
    return (n == 0) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/famiclone_sample_ctr.sv
// Saturating up-counter with a limit flag and a threshold flag, both computed on the value
// the counter takes at the coming edge so the caller can act in the same cycle.
module famiclone_sample_ctr #(
  parameter int unsigned LIMIT  = 3,
  parameter int unsigned THRESH = LIMIT,
  parameter int unsigned W      = 2
) (
  input  logic         clk_i,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o,
  output logic         below_o,
  output logic         reached_o,
  output logic         thresh_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign below_o = (32'(cnt_q) < LIMIT);

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && below_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o     = cnt_q;
  assign reached_o = (32'(cnt_d) == LIMIT);
  assign thresh_o  = (32'(cnt_d) >= THRESH);

endmodule

// File: rtl/famiclone_detect.sv
// Power-on famiclone probe: holds CIRAM /CE and /A13 low, then classifies the console from
// PPU read samples whose /A13 is or is not the inverse of A13.
module famiclone_detect
  import famiclone_detect_pkg::*;
#(
  parameter int unsigned INIT_CYCLES    = 15,
  parameter int unsigned N_LOW          = 3,
  parameter int unsigned N_HIGH         = 3,
  parameter int unsigned MISMATCH_MIN   = 1,
  parameter int unsigned TIMEOUT_CYCLES = 65535,
  parameter int unsigned MISMATCH_W     = 4
) (
  input  logic                  m2,
  input  logic                  rst,
  input  logic                  ppu_rd_evt,
  input  logic                  ppu_a13,
  input  logic                  ppu_not_a13,
  input  logic [1:0]            force_mode,
  output logic                  init_hold,
  output logic                  detect_done,
  output logic                  new_dendy,
  output logic [MISMATCH_W-1:0] mismatch_cnt
);

  localparam int unsigned IW     = ctr_w(INIT_CYCLES);
  localparam int unsigned LW     = ctr_w(N_LOW);
  localparam int unsigned HW     = ctr_w(N_HIGH);
  localparam int unsigned TW     = ctr_w(TIMEOUT_CYCLES);
  localparam int unsigned MM_LIM = (1 << MISMATCH_W) - 1;

  state_e        state_q;
  logic [IW-1:0] hold_q;
  logic          init_hold_q;
  logic          done_q;
  logic          dendy_q;

  logic          clr;
  logic          run_obs;
  logic          sample_vld;
  logic          low_below, low_reached, low_thr;
  logic          high_below, high_reached, high_thr;
  logic          mm_below, mm_reached, mm_hit;
  logic          to_below, to_reached, to_thr;
  logic [LW-1:0] low_cnt;
  logic [HW-1:0] high_cnt;
  logic [TW-1:0] to_cnt;
  logic          to_hit;
  logic          unused_ctr;

  // A re-run request behaves exactly like reset for every counter and the FSM.
  assign clr        = rst | (force_mode == FM_RERUN);
  assign run_obs    = (state_q == ST_OBSERVE) && (force_mode == FM_AUTO);
  assign sample_vld = run_obs && ppu_rd_evt && low_below && high_below;
  assign to_hit     = (TIMEOUT_CYCLES != 0) && to_reached;

  famiclone_sample_ctr #(.LIMIT(N_LOW), .W(LW)) u_low_ctr (
    .clk_i     (m2),
    .clr_i     (clr),
    .inc_i     (sample_vld && !ppu_a13),
    .cnt_o     (low_cnt),
    .below_o   (low_below),
    .reached_o (low_reached),
    .thresh_o  (low_thr)
  );

  famiclone_sample_ctr #(.LIMIT(N_HIGH), .W(HW)) u_high_ctr (
    .clk_i     (m2),
    .clr_i     (clr),
    .inc_i     (sample_vld && ppu_a13),
    .cnt_o     (high_cnt),
    .below_o   (high_below),
    .reached_o (high_reached),
    .thresh_o  (high_thr)
  );

  famiclone_sample_ctr #(.LIMIT(MM_LIM), .THRESH(MISMATCH_MIN), .W(MISMATCH_W)) u_mm_ctr (
    .clk_i     (m2),
    .clr_i     (clr),
    .inc_i     (sample_vld && (ppu_a13 == ppu_not_a13)),
    .cnt_o     (mismatch_cnt),
    .below_o   (mm_below),
    .reached_o (mm_reached),
    .thresh_o  (mm_hit)
  );

  famiclone_sample_ctr #(.LIMIT(TIMEOUT_CYCLES), .W(TW)) u_to_ctr (
    .clk_i     (m2),
    .clr_i     (clr),
    .inc_i     (run_obs),
    .cnt_o     (to_cnt),
    .below_o   (to_below),
    .reached_o (to_reached),
    .thresh_o  (to_thr)
  );

  assign unused_ctr = ^{low_cnt, high_cnt, to_cnt, low_thr, high_thr, to_thr,
                        mm_below, mm_reached, to_below};

  always_ff @(posedge m2) begin
    if (clr) begin
      state_q     <= ST_INIT;
      hold_q      <= IW'(INIT_CYCLES);
      init_hold_q <= 1'b1;
      done_q      <= 1'b0;
      dendy_q     <= 1'b0;
    end else if (force_mode == FM_ORIG || force_mode == FM_CLONE) begin
      state_q     <= ST_DONE;
      init_hold_q <= 1'b0;
      done_q      <= 1'b1;
      dendy_q     <= (force_mode == FM_CLONE);
    end else begin
      case (state_q)
        ST_INIT: begin
          if (hold_q != '0) begin
            hold_q <= hold_q - 1'b1;
          end
          if (hold_q == IW'(1)) begin
            state_q     <= ST_OBSERVE;
            init_hold_q <= 1'b0;
          end
        end
        ST_OBSERVE: begin
          // A mismatch seen on this edge outranks both sample completion and timeout.
          if (mm_hit) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
            dendy_q <= 1'b1;
          end else if (low_reached || high_reached || to_hit) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
            dendy_q <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign init_hold   = init_hold_q;
  assign detect_done = done_q;
  assign new_dendy   = dendy_q;

endmodule

// File: tb/tb_famiclone_detect.sv
// Directed bench for famiclone_detect: default instance plus a MISMATCH_MIN=2 instance on shared stimulus.
module tb_famiclone_detect;

  logic       m2 = 1'b0;
  logic       rst = 1'b1;
  logic       ppu_rd_evt = 1'b0;
  logic       ppu_a13 = 1'b0;
  logic       ppu_not_a13 = 1'b0;
  logic [1:0] force_mode = 2'b00;

  logic       init_hold, detect_done, new_dendy;
  logic [3:0] mismatch_cnt;
  logic       init_hold2, detect_done2, new_dendy2;
  logic [3:0] mismatch_cnt2;

  int checks = 0;
  int errors = 0;

  always #5 m2 = ~m2;

  famiclone_detect dut (
    .m2(m2), .rst(rst), .ppu_rd_evt(ppu_rd_evt), .ppu_a13(ppu_a13),
    .ppu_not_a13(ppu_not_a13), .force_mode(force_mode),
    .init_hold(init_hold), .detect_done(detect_done), .new_dendy(new_dendy),
    .mismatch_cnt(mismatch_cnt)
  );

  famiclone_detect #(.MISMATCH_MIN(2)) dut2 (
    .m2(m2), .rst(rst), .ppu_rd_evt(ppu_rd_evt), .ppu_a13(ppu_a13),
    .ppu_not_a13(ppu_not_a13), .force_mode(force_mode),
    .init_hold(init_hold2), .detect_done(detect_done2), .new_dendy(new_dendy2),
    .mismatch_cnt(mismatch_cnt2)
  );

  task automatic step();
    @(posedge m2);
    #1;
  endtask

  task automatic rd(input logic a, input logic na);
    ppu_rd_evt  = 1'b1;
    ppu_a13     = a;
    ppu_not_a13 = na;
    step();
    ppu_rd_evt  = 1'b0;
  endtask

  task automatic reset_to_observe();
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (15) step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++;
    if ({init_hold, detect_done, new_dendy, mismatch_cnt} !== 7'b1_0_0_0000) begin
      errors++;
      $display("FAIL reset_vals: got hold=%b done=%b dendy=%b mm=%0d, want 1 0 0 0",
               init_hold, detect_done, new_dendy, mismatch_cnt);
    end
    rst = 1'b0;
    repeat (14) step();
    checks++;
    if (init_hold !== 1'b1) begin
      errors++;
      $display("FAIL init_hold_c14: got %b want 1", init_hold);
    end
    step();
    checks++;
    if (init_hold !== 1'b0 || detect_done !== 1'b0) begin
      errors++;
      $display("FAIL init_hold_c15: got hold=%b done=%b want 0 0", init_hold, detect_done);
    end
    repeat (65534) step();
    checks++;
    if (detect_done !== 1'b0) begin
      errors++;
      $display("FAIL timeout_early: got done=%b want 0", detect_done);
    end
    step();
    checks++;
    if (detect_done !== 1'b1 || new_dendy !== 1'b0 || mismatch_cnt !== 4'd0) begin
      errors++;
      $display("FAIL timeout_hit: got done=%b dendy=%b mm=%0d want 1 0 0",
               detect_done, new_dendy, mismatch_cnt);
    end
  endtask

  task automatic test_alternating();
    reset_to_observe();
    rd(0, 1); rd(1, 0); rd(0, 1); rd(1, 0);
    checks++;
    if (detect_done !== 1'b0) begin
      errors++;
      $display("FAIL alt_4reads: got done=%b want 0", detect_done);
    end
    rd(0, 1);
    checks++;
    if (detect_done !== 1'b1 || new_dendy !== 1'b0 || mismatch_cnt !== 4'd0) begin
      errors++;
      $display("FAIL alt_5reads: got done=%b dendy=%b mm=%0d want 1 0 0",
               detect_done, new_dendy, mismatch_cnt);
    end
    rd(1, 1);
    checks++;
    if (detect_done !== 1'b1 || new_dendy !== 1'b0 || mismatch_cnt !== 4'd0) begin
      errors++;
      $display("FAIL done_frozen: got done=%b dendy=%b mm=%0d want 1 0 0",
               detect_done, new_dendy, mismatch_cnt);
    end
  endtask

  task automatic test_first_mismatch();
    reset_to_observe();
    rd(0, 0);
    checks++;
    if (detect_done !== 1'b1 || new_dendy !== 1'b1 || mismatch_cnt !== 4'd1) begin
      errors++;
      $display("FAIL first_mm: got done=%b dendy=%b mm=%0d want 1 1 1",
               detect_done, new_dendy, mismatch_cnt);
    end
    rd(1, 1);
    checks++;
    if (mismatch_cnt !== 4'd1) begin
      errors++;
      $display("FAIL mm_frozen: got mm=%0d want 1", mismatch_cnt);
    end
  endtask

  task automatic test_threshold();
    reset_to_observe();
    rd(0, 0);
    checks++;
    if (detect_done2 !== 1'b0 || mismatch_cnt2 !== 4'd1) begin
      errors++;
      $display("FAIL thr_one_mm: got done=%b mm=%0d want 0 1", detect_done2, mismatch_cnt2);
    end
    rd(0, 1); rd(0, 1);
    checks++;
    if (detect_done2 !== 1'b1 || new_dendy2 !== 1'b0 || mismatch_cnt2 !== 4'd1) begin
      errors++;
      $display("FAIL thr_low_limit: got done=%b dendy=%b mm=%0d want 1 0 1",
               detect_done2, new_dendy2, mismatch_cnt2);
    end
    reset_to_observe();
    rd(0, 0); rd(1, 1);
    checks++;
    if (detect_done2 !== 1'b1 || new_dendy2 !== 1'b1 || mismatch_cnt2 !== 4'd2) begin
      errors++;
      $display("FAIL thr_two_mm: got done=%b dendy=%b mm=%0d want 1 1 2",
               detect_done2, new_dendy2, mismatch_cnt2);
    end
  endtask

  task automatic test_init_events();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      ppu_rd_evt  = (i >= 3 && i <= 10);
      ppu_a13     = 1'b1;
      ppu_not_a13 = 1'b1;
      step();
    end
    ppu_rd_evt = 1'b0;
    checks++;
    if (mismatch_cnt !== 4'd0 || detect_done !== 1'b0 || init_hold !== 1'b0) begin
      errors++;
      $display("FAIL init_evt_ignored: got mm=%0d done=%b hold=%b want 0 0 0",
               mismatch_cnt, detect_done, init_hold);
    end
  endtask

  task automatic test_force();
    reset_to_observe();
    rd(0, 0);
    force_mode = 2'b11;
    step();
    force_mode = 2'b00;
    checks++;
    if ({init_hold, detect_done, new_dendy, mismatch_cnt} !== 7'b1_0_0_0000) begin
      errors++;
      $display("FAIL rerun: got hold=%b done=%b dendy=%b mm=%0d want 1 0 0 0",
               init_hold, detect_done, new_dendy, mismatch_cnt);
    end
    step();
    force_mode = 2'b01;
    step();
    checks++;
    if ({init_hold, detect_done, new_dendy} !== 3'b0_1_0) begin
      errors++;
      $display("FAIL force_orig: got hold=%b done=%b dendy=%b want 0 1 0",
               init_hold, detect_done, new_dendy);
    end
    force_mode = 2'b10;
    rd(0, 1);
    step();
    checks++;
    if (detect_done !== 1'b1 || new_dendy !== 1'b1) begin
      errors++;
      $display("FAIL force_clone: got done=%b dendy=%b want 1 1", detect_done, new_dendy);
    end
    force_mode = 2'b00;
    step();
    checks++;
    if (detect_done !== 1'b1 || new_dendy !== 1'b1) begin
      errors++;
      $display("FAIL force_release: got done=%b dendy=%b want 1 1", detect_done, new_dendy);
    end
    reset_to_observe();
    rd(0, 1);
    rst = 1'b1;
    step();
    checks++;
    if ({init_hold, detect_done, new_dendy, mismatch_cnt} !== 7'b1_0_0_0000) begin
      errors++;
      $display("FAIL rst_mid_obs: got hold=%b done=%b dendy=%b mm=%0d want 1 0 0 0",
               init_hold, detect_done, new_dendy, mismatch_cnt);
    end
    rst = 1'b0;
    repeat (15) step();
    rd(0, 1); rd(0, 1);
    checks++;
    if (detect_done !== 1'b0) begin
      errors++;
      $display("FAIL rst_clears_low: got done=%b want 0", detect_done);
    end
  endtask

  initial begin
    test_reset();
    test_alternating();
    test_first_mismatch();
    test_threshold();
    test_init_events();
    test_force();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/famiclone_detect.md
Name: famiclone_detect

Overview:
- Parametrised successor to the cartridge power-on famiclone probe: holds CIRAM /CE and /A13 low for a configurable number of M2 cycles, then observes PPU read samples to classify the console.
- Classes: original/compatible (internal NTRAM usable) or "new Dendy" clone (CIRAM /CE unused, /A13 not the inverse of A13).
- Adds a mismatch threshold, an observation timeout, a forced-mode override and a re-run request.
- Sits between the PPU capture logic and the CIRAM/NTRAM steering in the top level.

Parameters:
- INIT_CYCLES, 15, M2 cycles of power-on hold; must be ≥1.
- N_LOW, 3, PPU read samples with A13=0 to collect.
- N_HIGH, 3, PPU read samples with A13=1 to collect.
- MISMATCH_MIN, 1, mismatching samples required to declare a clone; must be ≥1.
- TIMEOUT_CYCLES, 65535, M2 cycles allowed in OBSERVE before giving up; 0 disables the timeout.
- MISMATCH_W, 4, width of the mismatch_cnt output.

Ports:
- m2  in  1  CPU M2 clock; all logic on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- ppu_rd_evt  in  1  one-cycle pulse per PPU read, already synchronised to m2.
- ppu_a13  in  1  PPU A13 sampled with the read.
- ppu_not_a13  in  1  /A13 pin sampled with the read.
- force_mode  in  2  00 auto, 01 force original, 10 force clone, 11 re-run detection.
- init_hold  out  1  1 = drive CIRAM /CE and /A13 low.
- detect_done  out  1  classification final.
- new_dendy  out  1  1 = clone detected or forced.
- mismatch_cnt  out  MISMATCH_W  saturating count of mismatching samples (debug).

Behaviour:
- Reset values: state INIT; init_hold=1; detect_done=0; new_dendy=0; mismatch_cnt=0; hold counter=INIT_CYCLES; low/high sample counters=0; timeout counter=0.
- Priority: rst > force_mode > normal operation.
- Sampling of force_mode: registered; it takes effect on the next edge and is evaluated every cycle.
  - 01/10: next state DONE, detect_done=1, new_dendy=0/1 respectively, init_hold=0. The forced result persists while force_mode is held; returning to 00 keeps the DONE result.
  - 11: equivalent to rst (back to INIT with all reset values) for as long as it is held.
- INIT:
  - Hold counter decrements each cycle.
  - When it is 1 at an edge, the next state is OBSERVE and init_hold falls on that edge, so init_hold is high for exactly INIT_CYCLES cycles after reset release.
  - ppu_rd_evt is ignored in INIT.
- OBSERVE: on a ppu_rd_evt cycle, a sample is valid only if low_cnt<N_LOW and high_cnt<N_HIGH, evaluated on pre-update values.
  - Valid sample with ppu_a13==ppu_not_a13 (mismatch): mismatch_cnt increments, saturating at 2^MISMATCH_W-1.
  - ppu_a13=0: low_cnt increments if below N_LOW. ppu_a13=1: high_cnt increments if below N_HIGH.
  - If the updated mismatch count ≥ MISMATCH_MIN: next state DONE, new_dendy=1, detect_done=1. Mismatch is checked before completion.
  - Else if the updated low_cnt==N_LOW or high_cnt==N_HIGH: no further valid samples are possible, so next state DONE, new_dendy=0, detect_done=1.
  - Timeout counter increments each OBSERVE cycle. On reaching TIMEOUT_CYCLES (when nonzero): DONE with new_dendy=0.
  - A read event and the timeout on the same edge: the sample is evaluated first; a mismatch result wins.
- DONE: all outputs frozen; ppu_rd_evt is ignored. Only rst or force_mode≠00 change state.
- All outputs are registered; no combinational path from inputs to outputs.
- Counter widths are sized with $clog2 of the parameter +1. Counters never wrap.

Decomposition:
- Shared package: state encoding constants (ST_INIT, ST_OBSERVE, ST_DONE) and force_mode codes (FM_AUTO, FM_ORIG, FM_CLONE, FM_RERUN). These are also used by the top-level CIRAM steering.
- One natural sub-module: famiclone_sample_ctr, a saturating up-counter with limit parameter and "reached" flag. It is instantiated for low, high, mismatch and timeout counting.
- The FSM stays in famiclone_detect.

Test Plan:
- Reset release, no events: init_hold=1 for exactly 15 cycles, then 0; detect_done stays 0 until the 65535-cycle timeout, then detect_done=1, new_dendy=0.
- After INIT, six reads with (a13, not_a13) alternating (0,1),(1,0): detect_done=1 on the edge after the third A13=0 read (both counters advance, first limit hit at read 5), new_dendy=0, mismatch_cnt=0.
- After INIT, first read (0,0): next edge detect_done=1, new_dendy=1, mismatch_cnt=1.
- MISMATCH_MIN=2: reads (0,0),(0,1),(0,1) → low limit hit with one mismatch, so new_dendy=0; repeat with (0,0),(1,1) → new_dendy=1 after the second read.
- ppu_rd_evt pulses during INIT (cycles 3..10) with mismatching data: ignored; mismatch_cnt=0 at end of INIT.
- In DONE with new_dendy=1, force_mode=11 for one cycle: next edge init_hold=1, detect_done=0, new_dendy=0; force_mode=01 at any point yields detect_done=1, new_dendy=0 next edge; rst asserted mid-OBSERVE returns all outputs to reset values next edge.
